bus_dma: RTL and testbench

- Bus initiator that copies or fills byte blocks through the memory bus: drives address, write data, bus enable and write enable, and reads returned data.
- Sits beside the CPU in front of memory_bus, which routes its accesses to RAM, ROM, peripherals or block RAM exactly as it routes CPU accesses.
- Uses a request/grant handshake with the top-level arbiter so the CPU yields the bus while a transfer runs.

---
 rtl/bus_dma.sv | 168 ++++++++++++++++
 tb/tb_bus_dma.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma.sv
// bus_dma: bus initiator that copies byte blocks through the memory bus under a
// request/grant handshake. Define DMA_FILL_EN to enable the constant-fill mode.
module bus_dma #(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] src_address,
    input  logic [15:0] dst_address,
    input  logic [15:0] count,
    input  logic        fill,
    input  logic [7:0]  fill_value,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    input  logic [7:0]  mem_data_in,
    output logic        mem_bus_enable,
    output logic        mem_write_enable,
    output logic        busy,
    output logic        done,
    output logic [15:0] remaining
);

    typedef enum logic [2:0] {IDLE, REQUEST, READ, WRITE, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);

    state_t      state;
    state_t      next_state;
    logic [15:0] src_ptr;
    logic [15:0] dst_ptr;
    logic [7:0]  data_reg;
    logic [2:0]  wait_cnt;
    logic        read_last;
    logic        fill_active;

    assign read_last = (wait_cnt == WAIT_LAST);

`ifdef DMA_FILL_EN
    logic fill_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fill_mode <= 1'b0;
        else if (state == IDLE && start)
            fill_mode <= fill;
    end

    assign fill_active = fill_mode;
`else
    logic unused_fill;

    assign unused_fill = ^{fill, fill_value};
    assign fill_active = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state       = state;
        bus_request      = 1'b0;
        mem_bus_enable   = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_data_out     = '0;

        case (state)
            IDLE: begin
                if (start)
                    next_state = (count == 16'd0) ? DONE : REQUEST;
            end
            REQUEST: begin
                bus_request = 1'b1;
                if (bus_grant)
                    next_state = fill_active ? WRITE : READ;
            end
            READ: begin
                bus_request    = 1'b1;
                mem_bus_enable = 1'b1;
                mem_address    = src_ptr;
                if (read_last)
                    next_state = WRITE;
            end
            WRITE: begin
                bus_request      = 1'b1;
                mem_bus_enable   = 1'b1;
                mem_write_enable = 1'b1;
                mem_address      = dst_ptr;
                mem_data_out     = data_reg;
                if (remaining == 16'd1)
                    next_state = DONE;
                else if (bus_grant)
                    next_state = fill_active ? WRITE : READ;
                else
                    next_state = REQUEST;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // abort overrides everything except a start in IDLE
        if (abort && state != IDLE)
            next_state = IDLE;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            data_reg  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_address;
                        dst_ptr   <= dst_address;
                        remaining <= count;
`ifdef DMA_FILL_EN
                        if (fill)
                            data_reg <= fill_value;
`endif
                    end
                end
                READ: begin
                    if (read_last)
                        data_reg <= mem_data_in;
                end
                WRITE: begin
                    // the write strobe is already on the bus, so bookkeeping
                    // advances even when abort ends the transfer here
                    if (!fill_active)
                        src_ptr <= src_ptr + 16'd1;
                    dst_ptr   <= dst_ptr + 16'd1;
                    remaining <= remaining - 16'd1;
                end
                default: begin
                end
            endcase

            if (state == READ && next_state == READ)
                wait_cnt <= wait_cnt + 3'd1;
            else
                wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// Directed self-checking bench for bus_dma (READ_WAIT=1) with a registered-read
// byte memory model; covers copy, zero count, wrap, grant loss, abort and reset.
`timescale 1ns/1ps
module tb_bus_dma;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] src_address;
    logic [15:0] dst_address;
    logic [15:0] count;
    logic        fill;
    logic [7:0]  fill_value;
    logic        bus_request;
    logic        bus_grant;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic        mem_bus_enable;
    logic        mem_write_enable;
    logic        busy;
    logic        done;
    logic [15:0] remaining;

    bus_dma #(.READ_WAIT(1)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .src_address      (src_address),
        .dst_address      (dst_address),
        .count            (count),
        .fill             (fill),
        .fill_value       (fill_value),
        .bus_request      (bus_request),
        .bus_grant        (bus_grant),
        .mem_address      (mem_address),
        .mem_data_out     (mem_data_out),
        .mem_data_in      (mem_data_in),
        .mem_bus_enable   (mem_bus_enable),
        .mem_write_enable (mem_write_enable),
        .busy             (busy),
        .done             (done),
        .remaining        (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // byte memory with one cycle of read latency, plus a bench-side write port
    logic [7:0]  mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [7:0]  tb_wdata;

    always @(posedge clk) begin
        mem_data_in <= mem[mem_address];
        if (tb_we)
            mem[tb_addr] <= tb_wdata;
        else if (mem_bus_enable && mem_write_enable)
            mem[mem_address] <= mem_data_out;
    end

    // bus activity monitor, sampled mid-cycle
    int          en_cyc = 0;
    int          wr_cyc = 0;
    int          req_cyc = 0;
    int          done_cyc = 0;
    logic        prev_rd = 1'b0;
    logic [15:0] rd_addr_q[$];
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    always @(negedge clk) begin
        if (mem_bus_enable)
            en_cyc++;
        if (mem_bus_enable && mem_write_enable) begin
            wr_cyc++;
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_data_out);
        end
        if (mem_bus_enable && !mem_write_enable && !prev_rd)
            rd_addr_q.push_back(mem_address);
        prev_rd = mem_bus_enable && !mem_write_enable;
        if (bus_request)
            req_cyc++;
        if (done)
            done_cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int n_assert = 0;
    int n_fail = 0;
    int en0, wr0, req0, done0, rd0, wq0, cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_we    = 1'b1;
        tb_addr  = a;
        tb_wdata = d;
        step(1);
        tb_we    = 1'b0;
    endtask

    task automatic snap();
        en0   = en_cyc;
        wr0   = wr_cyc;
        req0  = req_cyc;
        done0 = done_cyc;
        rd0   = rd_addr_q.size();
        wq0   = wr_addr_q.size();
    endtask

    task automatic start_xfer(input logic [15:0] src, input logic [15:0] dst,
                              input logic [15:0] cnt, input logic fl, input logic [7:0] fv);
        src_address = src;
        dst_address = dst;
        count       = cnt;
        fill        = fl;
        fill_value  = fv;
        start       = 1'b1;
        step(1);
        start       = 1'b0;
        src_address = 16'h5555;
        dst_address = 16'hAAAA;
        count       = 16'h7777;
        fill        = 1'b0;
        fill_value  = 8'h3C;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            step(1);
            cycles++;
        end
        check(tag, done, 1);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        fill        = 1'b0;
        fill_value  = '0;
        src_address = '0;
        dst_address = '0;
        count       = '0;
        bus_grant   = 1'b0;
        tb_we       = 1'b0;
        tb_addr     = '0;
        tb_wdata    = '0;

        // reset is asynchronous: outputs must be clear before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", bus_request, 0);
        check("rst_strobes", {mem_bus_enable, mem_write_enable}, 0);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_data_out, 0);
        check("rst_remaining", remaining, 0);
        step(2);
        reset = 1'b0;
        step(1);

        // copy 4 bytes, continuous grant
        poke(16'h0100, 8'h11);
        poke(16'h0101, 8'h22);
        poke(16'h0102, 8'h33);
        poke(16'h0103, 8'h44);
        bus_grant = 1'b1;
        snap();
        start_xfer(16'h0100, 16'hC000, 16'd4, 1'b0, 8'h00);
        check("t1_busy", busy, 1);
        wait_done("t1_done", 40, cyc);
        check("t1_latency", cyc, 13);
        check("t1_remaining", remaining, 0);
        step(1);
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);
        check("t1_data", {mem[16'hC000], mem[16'hC001], mem[16'hC002], mem[16'hC003]}, 32'h11223344);
        check("t1_done_count", done_cyc - done0, 1);
        check("t1_writes", wr_cyc - wr0, 4);
        check("t1_bus_cycles", en_cyc - en0, 12);

        // zero count goes straight to DONE without touching the bus
        snap();
        start_xfer(16'h1234, 16'h4321, 16'd0, 1'b0, 8'h00);
        check("t2_done_next", done, 1);
        step(1);
        check("t2_done_pulse", done, 0);
        check("t2_idle", busy, 0);
        check("t2_no_enable", en_cyc - en0, 0);
        check("t2_no_request", req_cyc - req0, 0);
        check("t2_done_count", done_cyc - done0, 1);

        // source pointer wraps from 0xFFFF to 0x0000
        poke(16'hFFFF, 8'h5A);
        poke(16'h0000, 8'h6B);
        snap();
        start_xfer(16'hFFFF, 16'h0010, 16'd2, 1'b0, 8'h00);
        wait_done("t3_done", 20, cyc);
        check("t3_reads", rd_addr_q.size() - rd0, 2);
        check("t3_rd0", rd_addr_q[rd0], 16'hFFFF);
        check("t3_rd1", rd_addr_q[rd0 + 1], 16'h0000);
        check("t3_wr0", {wr_addr_q[wq0], wr_data_q[wq0]}, 24'h00105A);
        check("t3_wr1", {wr_addr_q[wq0 + 1], wr_data_q[wq0 + 1]}, 24'h00116B);
        step(1);

        // late grant, then grant lost after the first write
        poke(16'h0200, 8'h81);
        poke(16'h0201, 8'h82);
        bus_grant = 1'b0;
        snap();
        start_xfer(16'h0200, 16'h0300, 16'd2, 1'b0, 8'h00);
        step(5);
        check("t4_req_held", req_cyc - req0, 5);
        check("t4_no_strobe", en_cyc - en0, 0);
        check("t4_req_now", bus_request, 1);
        bus_grant = 1'b1;
        cyc = 0;
        while (mem_write_enable !== 1'b1 && cyc < 10) begin
            step(1);
            cyc++;
        end
        check("t4_first_write", mem_write_enable, 1);
        check("t4_write_delay", cyc, 3);
        check("t4_write_addr", mem_address, 16'h0300);
        bus_grant = 1'b0;
        step(1);
        check("t4_back_to_req", {bus_request, mem_bus_enable}, 2'b10);
        check("t4_remaining", remaining, 1);
        en0 = en_cyc;
        step(3);
        check("t4_quiet", en_cyc - en0, 0);
        bus_grant = 1'b1;
        wait_done("t4_done", 20, cyc);
        check("t4_rd1", rd_addr_q[rd0 + 1], 16'h0201);
        check("t4_wr1", {wr_addr_q[wq0 + 1], wr_data_q[wq0 + 1]}, 24'h030182);
        check("t4_mem", {mem[16'h0300], mem[16'h0301]}, 16'h8182);
        step(1);

        // abort during the second read
        poke(16'h0400, 8'h01);
        poke(16'h0401, 8'h02);
        poke(16'h0402, 8'h03);
        poke(16'h0403, 8'h04);
        poke(16'h0500, 8'hEE);
        poke(16'h0501, 8'hEE);
        snap();
        start_xfer(16'h0400, 16'h0500, 16'd4, 1'b0, 8'h00);
        cyc = 0;
        while (!(mem_bus_enable && !mem_write_enable && (wr_cyc - wr0) == 1) && cyc < 20) begin
            step(1);
            cyc++;
        end
        check("t5_second_read", mem_address, 16'h0401);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t5_idle", busy, 0);
        check("t5_remaining", remaining, 3);
        step(3);
        check("t5_no_done", done_cyc - done0, 0);
        check("t5_writes", wr_cyc - wr0, 1);
        check("t5_bus_cycles", en_cyc - en0, 4);
        check("t5_mem", {mem[16'h0500], mem[16'h0501]}, 16'h01EE);

        // start and abort together in IDLE: start wins
        poke(16'h0600, 8'h3C);
        abort = 1'b1;
        start_xfer(16'h0600, 16'h0700, 16'd1, 1'b0, 8'h00);
        abort = 1'b0;
        check("t6_started", busy, 1);
        wait_done("t6_done", 20, cyc);
        check("t6_mem", mem[16'h0700], 8'h3C);
        step(1);

`ifdef DMA_FILL_EN
        // fill mode: three back-to-back writes, no reads
        poke(16'h0200, 8'h00);
        poke(16'h0201, 8'h00);
        poke(16'h0202, 8'h00);
        snap();
        start_xfer(16'h1000, 16'h0200, 16'd3, 1'b1, 8'hA5);
        wait_done("t7_done", 20, cyc);
        check("t7_latency", cyc, 4);
        check("t7_no_reads", rd_addr_q.size() - rd0, 0);
        check("t7_bus_cycles", en_cyc - en0, 3);
        check("t7_writes", wr_cyc - wr0, 3);
        check("t7_mem", {mem[16'h0200], mem[16'h0201], mem[16'h0202]}, 24'hA5A5A5);
`else
        // without the fill feature a fill request is an ordinary copy
        poke(16'h0900, 8'hD1);
        poke(16'h0901, 8'hD2);
        poke(16'h0902, 8'hD3);
        snap();
        start_xfer(16'h0900, 16'h0200, 16'd3, 1'b1, 8'hA5);
        wait_done("t7_done", 30, cyc);
        check("t7_latency", cyc, 10);
        check("t7_reads", rd_addr_q.size() - rd0, 3);
        check("t7_writes", wr_cyc - wr0, 3);
        check("t7_mem", {mem[16'h0200], mem[16'h0201], mem[16'h0202]}, 24'hD1D2D3);
`endif
        step(1);

        // asynchronous reset mid-transfer drops the strobes at once
        start_xfer(16'h0400, 16'h0600, 16'd4, 1'b0, 8'h00);
        step(1);
        check("t8_reading", mem_bus_enable, 1);
        #2 reset = 1'b1;
        #1;
        check("t8_strobes", {mem_bus_enable, mem_write_enable, bus_request}, 0);
        check("t8_busy", busy, 0);
        check("t8_addr", mem_address, 0);
        check("t8_remaining", remaining, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(2);
        check("t8_stays_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
